// File: rtl/chan_accum_if.sv
// Handshake bundle for chan_accum_param: sample input side and per-channel result side.
interface chan_accum_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int CHW       = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [CHW-1:0]       in_ch;
  logic [WIDTH-1:0]     in_data;
  logic                 in_clr;
  logic                 out_valid;
  logic                 out_ready;
  logic [CHW-1:0]       out_ch;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_ovf;

  modport master (
    output in_valid, in_ch, in_data, in_clr, out_ready,
    input  in_ready, out_valid, out_ch, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_ch, in_data, in_clr, out_ready,
    output in_ready, out_valid, out_ch, out_data, out_ovf
  );
endinterface

// File: rtl/chan_accum_param.sv
// Multi-channel running accumulator with a one-entry registered result stage.
// Define ACC_SATURATE_EN to clamp on overflow instead of wrapping modulo 2**ACC_WIDTH.
module chan_accum_param #(
  parameter int                   WIDTH     = 8,
  parameter int                   ACC_WIDTH = 16,
  parameter int                   CHANNELS  = 4,
  parameter int                   CHW       = 8,
  parameter logic [ACC_WIDTH-1:0] INIT      = ACC_WIDTH'(2)
) (
  input logic         clk,
  input logic         rst,
  chan_accum_if.slave bus
);

  logic [ACC_WIDTH-1:0] acc [CHANNELS];
  logic                 out_valid_q;
  logic [CHW-1:0]       out_ch_q;
  logic [ACC_WIDTH-1:0] out_data_q;
  logic                 out_ovf_q;

  logic                 in_ready;
  logic                 accept;
  logic                 ch_ok;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] result;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign ch_ok    = 32'(bus.in_ch) < CHANNELS;

  // Loop-based select keeps the index width independent of CHW and never reads past CHANNELS.
  always_comb begin
    base = INIT;
    if (!bus.in_clr) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (32'(bus.in_ch) == i) base = acc[i];
      end
    end
  end

  assign sum = {1'b0, base} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, bus.in_data};

`ifdef ACC_SATURATE_EN
  assign result = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
  assign result = sum[ACC_WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= INIT;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (accept && ch_ok) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (32'(bus.in_ch) == i) acc[i] <= result;
      end
      out_valid_q <= 1'b1;
      out_ch_q    <= bus.in_ch;
      out_data_q  <= result;
      out_ovf_q   <= sum[ACC_WIDTH];
    end else if (in_ready) begin
      // Either the result was taken or nothing was held; a discarded sample leaves no result.
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_chan_accum_param.sv
// Directed bench for chan_accum_param: four instances cover default, INIT override,
// narrow accumulator overflow and a three-channel build with an out-of-range index.
module tb_chan_accum_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  chan_accum_if #(.WIDTH(8), .ACC_WIDTH(16), .CHW(8)) if0 ();
  chan_accum_if #(.WIDTH(8), .ACC_WIDTH(16), .CHW(8)) if1 ();
  chan_accum_if #(.WIDTH(8), .ACC_WIDTH(8),  .CHW(8)) if2 ();
  chan_accum_if #(.WIDTH(8), .ACC_WIDTH(16), .CHW(8)) if3 ();

  chan_accum_param u_def (.clk(clk), .rst(rst), .bus(if0.slave));

  chan_accum_param u_init (.clk(clk), .rst(rst), .bus(if1.slave));
  defparam u_init.INIT = 16'($rtoi(3.1415));

  chan_accum_param #(.WIDTH(8), .ACC_WIDTH(8), .INIT(8'd0))
    u_narrow (.clk(clk), .rst(rst), .bus(if2.slave));

  chan_accum_param #(.CHANNELS(3))
    u_ch3 (.clk(clk), .rst(rst), .bus(if3.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {if0.in_valid, if0.in_clr, if0.out_ready, if0.in_ch, if0.in_data} = '0;
    {if1.in_valid, if1.in_clr, if1.out_ready, if1.in_ch, if1.in_data} = '0;
    {if2.in_valid, if2.in_clr, if2.out_ready, if2.in_ch, if2.in_data} = '0;
    {if3.in_valid, if3.in_clr, if3.out_ready, if3.in_ch, if3.in_data} = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(if0.out_valid), 32'd0);
    chk("rst_out_data",  32'(if0.out_data),  32'd0);
    chk("rst_out_ovf",   32'(if0.out_ovf),   32'd0);
    chk("rst_in_ready",  32'(if0.in_ready),  32'd1);

    // back-to-back adds on channel 1 from INIT=2
    if0.out_ready = 1'b1;
    if0.in_valid = 1'b1; if0.in_ch = 8'd1; if0.in_data = 8'd5;
    tick();
    chk("t1_valid_a", 32'(if0.out_valid), 32'd1);
    chk("t1_data_a",  32'(if0.out_data),  32'd7);
    chk("t1_ch_a",    32'(if0.out_ch),    32'd1);
    chk("t1_ovf_a",   32'(if0.out_ovf),   32'd0);
    if0.in_data = 8'd7;
    tick();
    chk("t1_data_b",  32'(if0.out_data),  32'd14);
    chk("t1_ch_b",    32'(if0.out_ch),    32'd1);
    if0.in_valid = 1'b0;
    tick();
    chk("t1_drain",   32'(if0.out_valid), 32'd0);

    // INIT override 3.1415 -> 3
    if1.out_ready = 1'b1;
    if1.in_valid = 1'b1; if1.in_ch = 8'd0; if1.in_data = 8'd1;
    tick();
    chk("t2_data",    32'(if1.out_data), 32'd4);
    if1.in_clr = 1'b1; if1.in_data = 8'd0;
    tick();
    chk("t2_clr",     32'(if1.out_data), 32'd3);
    if1.in_clr = 1'b0; if1.in_data = 8'd255;
    tick();
    chk("t2_wide",    32'(if1.out_data), 32'd258);
    chk("t2_wide_ovf", 32'(if1.out_ovf), 32'd0);
    if1.in_valid = 1'b0;

    // 8-bit accumulator overflow on channel 2
    if2.out_ready = 1'b1;
    if2.in_valid = 1'b1; if2.in_ch = 8'd2; if2.in_data = 8'd200;
    tick();
    chk("t3_first",     32'(if2.out_data), 32'd200);
    chk("t3_first_ovf", 32'(if2.out_ovf),  32'd0);
    if2.in_data = 8'd100;
    tick();
`ifdef ACC_SATURATE_EN
    chk("t3_ovf_data", 32'(if2.out_data), 32'd255);
`else
    chk("t3_ovf_data", 32'(if2.out_data), 32'd44);
`endif
    chk("t3_ovf_flag", 32'(if2.out_ovf), 32'd1);
    if2.in_data = 8'd1;
    tick();
`ifdef ACC_SATURATE_EN
    chk("t3_next_data", 32'(if2.out_data), 32'd255);
    chk("t3_next_ovf",  32'(if2.out_ovf),  32'd1);
`else
    chk("t3_next_data", 32'(if2.out_data), 32'd45);
    chk("t3_next_ovf",  32'(if2.out_ovf),  32'd0);
`endif
    if2.in_valid = 1'b0;

    // backpressure: result held three cycles, then release accepts same edge
    if0.out_ready = 1'b0;
    if0.in_valid = 1'b1; if0.in_ch = 8'd0; if0.in_data = 8'd3;
    tick();
    chk("t4_valid", 32'(if0.out_valid), 32'd1);
    if0.in_data = 8'd4;
    for (int k = 0; k < 3; k++) begin
      chk("t4_in_ready", 32'(if0.in_ready), 32'd0);
      chk("t4_hold_data", 32'(if0.out_data), 32'd5);
      chk("t4_hold_ch",   32'(if0.out_ch),   32'd0);
      tick();
    end
    chk("t4_hold_end", 32'(if0.out_data), 32'd5);
    if0.out_ready = 1'b1;
    #1;
    chk("t4_release_ready", 32'(if0.in_ready), 32'd1);
    tick();
    chk("t4_release_data",  32'(if0.out_data),  32'd9);
    chk("t4_release_valid", 32'(if0.out_valid), 32'd1);
    if0.in_valid = 1'b0;
    tick();
    chk("t4_drain", 32'(if0.out_valid), 32'd0);

    // out-of-range channel is discarded, then clear on ch0
    if3.out_ready = 1'b1;
    if3.in_valid = 1'b1; if3.in_ch = 8'd3; if3.in_data = 8'd9;
    tick();
    chk("t5_discard_valid", 32'(if3.out_valid), 32'd0);
    chk("t5_discard_ready", 32'(if3.in_ready),  32'd1);
    if3.in_ch = 8'd0; if3.in_clr = 1'b1; if3.in_data = 8'd2;
    tick();
    chk("t5_clr_data", 32'(if3.out_data), 32'd4);
    if3.in_clr = 1'b0; if3.in_ch = 8'd1; if3.in_data = 8'd0;
    tick();
    chk("t5_ch1_unchanged", 32'(if3.out_data), 32'd2);
    if3.in_ch = 8'd2;
    tick();
    chk("t5_ch2_unchanged", 32'(if3.out_data), 32'd2);
    if3.in_valid = 1'b0;

    // reset while a result is held
    if0.out_ready = 1'b0;
    if0.in_valid = 1'b1; if0.in_ch = 8'd1; if0.in_data = 8'd1;
    tick();
    chk("t6_pre_data", 32'(if0.out_data), 32'd15);
    if0.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_valid", 32'(if0.out_valid), 32'd0);
    chk("t6_rst_ready", 32'(if0.in_ready),  32'd1);
    if0.out_ready = 1'b1;
    if0.in_valid = 1'b1; if0.in_ch = 8'd1; if0.in_data = 8'd0;
    tick();
    chk("t6_init_data", 32'(if0.out_data), 32'd2);
    chk("t6_init_ch",   32'(if0.out_ch),   32'd1);
    if0.in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
